sync_toggle_rx_mc: RTL and testbench



---
 rtl/sync_toggle_pkg.sv | 32 +++
 rtl/sync_ndff_p.sv | 23 ++
 rtl/sync_toggle_rx_mc.sv | 119 +++++++++++
 tb/tb_sync_toggle_rx_mc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_toggle_pkg.sv
// Shared helpers for the multi-channel toggle receiver: id-width sizing,
// round-robin channel search and the default synchroniser depth.
package sync_toggle_pkg;

    localparam int DEFAULT_STAGES = 2;
    localparam int MAX_CH         = 32;

    function automatic int id_width(input int ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

    // First set request after ptr, wrapping; scanning offsets downward lets the
    // nearest candidate overwrite any farther one.
    function automatic int rr_next(input logic [MAX_CH-1:0] req, input int ptr, input int ch);
        int idx;
        int pick;
        pick = 0;
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= ch) begin
                idx = ptr + k;
                if (idx >= ch) begin
                    idx = idx - ch;
                end
                if (req[idx[4:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sync_ndff_p.sv
// Single-bit STAGES-deep synchroniser with synchronous active-high reset.
module sync_ndff_p #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_toggle_rx_mc.sv
// Multi-channel toggle receiver: synchronise, edge-detect, count, and drain events
// round-robin. Optional macro SYNC_TOGGLE_RST_BLANK_EN blanks edges after reset.
module sync_toggle_rx_mc
    import sync_toggle_pkg::*;
#(
    parameter  int CH     = 4,
    parameter  int STAGES = DEFAULT_STAGES,
    parameter  int CNT_W  = 4,
    localparam int ID_W   = id_width(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   tog_in,
    output logic [CH-1:0]   pulse_out,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [ID_W-1:0] ev_ch,
    output logic [CH-1:0]   ovf,
    input  logic [CH-1:0]   ovf_clr
);

    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    logic [CH-1:0]     sync_last;
    logic [CH-1:0]     prev;
    logic [CH-1:0]     tog_edge;
    logic [CH-1:0]     pend_nz;
    logic [CH-1:0]     ld_vec;
    logic [CH-1:0]     ovf_set;
    logic [CNT_W-1:0]  pend [CH];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel;
    logic [MAX_CH-1:0] req_ext;
    logic              slot_free;
    logic              load;
    logic              blanking;

    for (genvar g = 0; g < CH; g++) begin : g_sync
        sync_ndff_p #(.STAGES(STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (tog_in[g]),
            .q   (sync_last[g])
        );
    end

`ifdef SYNC_TOGGLE_RST_BLANK_EN
    // Blank until the synchroniser and prev both carry post-reset levels.
    localparam int BLANK_W = $clog2(STAGES + 2);
    logic [BLANK_W-1:0] blank_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_cnt <= BLANK_W'(STAGES + 1);
        end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - 1'b1;
        end
    end

    assign blanking = (blank_cnt != '0);
`else
    assign blanking = 1'b0;
`endif

    always_comb begin
        tog_edge  = blanking ? '0 : (sync_last ^ prev);
        req_ext   = '0;
        for (int i = 0; i < CH; i++) begin
            pend_nz[i] = (pend[i] != '0);
        end
        req_ext[CH-1:0] = pend_nz;
        slot_free = !ev_valid || ev_ready;
        load      = slot_free && (|pend_nz);
        sel       = ID_W'(rr_next(req_ext, int'(rr_ptr), CH));
        ld_vec    = '0;
        if (load) begin
            ld_vec[sel] = 1'b1;
        end
        for (int i = 0; i < CH; i++) begin
            ovf_set[i] = tog_edge[i] && !ld_vec[i] && (pend[i] == PEND_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            pulse_out <= '0;
            ovf       <= '0;
            ev_valid  <= 1'b0;
            ev_ch     <= '0;
            rr_ptr    <= ID_W'(CH - 1);
            for (int i = 0; i < CH; i++) begin
                pend[i] <= '0;
            end
        end else begin
            prev      <= sync_last;
            pulse_out <= tog_edge;
            ovf       <= ovf_set | (ovf & ~ovf_clr);
            // An arrival and a load on the same channel cancel out.
            for (int i = 0; i < CH; i++) begin
                if (tog_edge[i] && !ld_vec[i]) begin
                    if (pend[i] != PEND_MAX) begin
                        pend[i] <= pend[i] + 1'b1;
                    end
                end else if (!tog_edge[i] && ld_vec[i]) begin
                    pend[i] <= pend[i] - 1'b1;
                end
            end
            if (slot_free) begin
                ev_valid <= load;
                if (load) begin
                    ev_ch  <= sel;
                    rr_ptr <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_toggle_rx_mc.sv
// Scoreboard bench for sync_toggle_rx_mc with CH=4, STAGES=2, CNT_W=2.
module tb_sync_toggle_rx_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tog_in = 4'b0000;
    logic [3:0] pulse_out;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_ch;
    logic [3:0] ovf;
    logic [3:0] ovf_clr = 4'b0000;

    int         checks = 0;
    int         errors = 0;
    int         beats  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_ch;

    sync_toggle_rx_mc #(.CH(4), .STAGES(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .pulse_out (pulse_out),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_ch     (ev_ch),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Every accepted beat must match the oldest expected channel.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat_unexpected got ch=%0d required no beat", ev_ch);
            end else begin
                exp_ch = exp_q.pop_front();
                if (ev_ch !== exp_ch) begin
                    errors++;
                    $display("[TB] FAIL beat_channel got ch=%0d required ch=%0d", ev_ch, exp_ch);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tog_in   = 4'b0000;
        ev_ready = 1'b0;
        ovf_clr  = 4'b0000;
        tick(3);
        rst = 1'b0;
        exp_q.delete();
        tick(2);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tog_in = 4'b0000;
        tick(3);
        checks++;
        if (pulse_out !== 4'b0000 || ev_valid !== 1'b0 || ovf !== 4'b0000 || ev_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got pulse=%b valid=%b ovf=%b ch=%0d required 0000 0 0000 0",
                     pulse_out, ev_valid, ovf, ev_ch);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single_event();
        do_reset();
        ev_ready  = 1'b1;
        tog_in[1] = 1'b1;
        exp_q.push_back(2'd1);
        tick(2);
        checks++;
        if (pulse_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL single_pulse_early got %b required 0000", pulse_out);
        end
        tick(1);
        checks++;
        if (pulse_out !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_pulse got %b required 0010", pulse_out);
        end
        tick(1);
        checks++;
        if (pulse_out !== 4'b0000 || ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_beat got pulse=%b valid=%b ch=%0d required 0000 1 1",
                     pulse_out, ev_valid, ev_ch);
        end
        tick(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle got valid=%b required 0", ev_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] order [3];
        order[0] = 2'd0;
        order[1] = 2'd2;
        order[2] = 2'd3;
        do_reset();
        ev_ready = 1'b1;
        tog_in   = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(order[i]);
        end
        tick(4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_ch !== order[i]) begin
                errors++;
                $display("[TB] FAIL simul_beat%0d got valid=%b ch=%0d required 1 %0d",
                         i, ev_valid, ev_ch, order[i]);
            end
            tick(1);
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_idle got valid=%b required 0", ev_valid);
        end
    endtask

    task automatic test_saturation();
        int b0;
        do_reset();
        ev_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tog_in[1] = ~tog_in[1];
            exp_q.push_back(2'd1);
            tick(4);
        end
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL sat_no_ovf_yet got %b required 0000", ovf);
        end
        tog_in[1] = ~tog_in[1];
        tick(4);
        checks++;
        if (ovf !== 4'b0010 || ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
            errors++;
            $display("[TB] FAIL sat_ovf got ovf=%b valid=%b ch=%0d required 0010 1 1",
                     ovf, ev_valid, ev_ch);
        end
        b0       = beats;
        ev_ready = 1'b1;
        tick(8);
        checks++;
        if (beats - b0 != 4 || ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sat_drain got beats=%0d valid=%b required 4 0", beats - b0, ev_valid);
        end
        checks++;
        if (ovf !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL ovf_sticky got %b required 0010", ovf);
        end
        ovf_clr = 4'b0010;
        tick(1);
        ovf_clr = 4'b0000;
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL ovf_clear got %b required 0000", ovf);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ev_ready  = 1'b0;
        tog_in[2] = 1'b1;
        exp_q.push_back(2'd2);
        tick(5);
        tog_in[0] = 1'b1;
        exp_q.push_back(2'd0);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (ev_valid !== 1'b1 || ev_ch !== 2'd2) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got valid=%b ch=%0d required 1 2", i, ev_valid, ev_ch);
            end
        end
        ev_ready = 1'b1;
        tick(1);
        checks++;
        if (ev_valid !== 1'b1 || ev_ch !== 2'd0) begin
            errors++;
            $display("[TB] FAIL bp_next got valid=%b ch=%0d required 1 0", ev_valid, ev_ch);
        end
        tick(1);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_idle got valid=%b required 0", ev_valid);
        end
    endtask

    task automatic test_reset_midstream();
        int b0;
        do_reset();
        ev_ready  = 1'b0;
        tog_in[1] = 1'b1;
        exp_q.push_back(2'd1);
        tick(5);
        tog_in[3] = 1'b1;
        exp_q.push_back(2'd3);
        tick(4);
        checks++;
        if (ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
            errors++;
            $display("[TB] FAIL mid_preload got valid=%b ch=%0d required 1 1", ev_valid, ev_ch);
        end
        rst    = 1'b1;
        tog_in = 4'b0000;
        tick(1);
        checks++;
        if (ev_valid !== 1'b0 || ev_ch !== 2'd0 || pulse_out !== 4'b0000 || ovf !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid=%b ch=%0d pulse=%b ovf=%b required 0 0 0000 0000",
                     ev_valid, ev_ch, pulse_out, ovf);
        end
        exp_q.delete();
        tick(1);
        rst      = 1'b0;
        ev_ready = 1'b1;
        b0       = beats;
        tick(8);
        checks++;
        if (beats != b0 || ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_discard got beats=%0d valid=%b required 0 0", beats - b0, ev_valid);
        end
    endtask

    task automatic test_level_held();
        int         npulse;
        int         exp_n;
        logic [3:0] exp_p;
`ifdef SYNC_TOGGLE_RST_BLANK_EN
        exp_n = 0;
        exp_p = 4'b0000;
`else
        exp_n = 1;
        exp_p = 4'b1000;
`endif
        rst      = 1'b1;
        tog_in   = 4'b1000;
        ev_ready = 1'b1;
        tick(3);
        exp_q.delete();
        if (exp_n == 1) begin
            exp_q.push_back(2'd3);
        end
        rst    = 1'b0;
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (pulse_out[3] === 1'b1) begin
                npulse++;
            end
            if (i == 2) begin
                checks++;
                if (pulse_out !== exp_p) begin
                    errors++;
                    $display("[TB] FAIL held_pulse_timing got %b required %b", pulse_out, exp_p);
                end
            end
        end
        checks++;
        if (npulse != exp_n) begin
            errors++;
            $display("[TB] FAIL held_pulse_count got %0d required %0d", npulse, exp_n);
        end
        tick(2);
        checks++;
        if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_events got pending=%0d valid=%b required 0 0", exp_q.size(), ev_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_simultaneous();
        test_saturation();
        test_backpressure();
        test_reset_midstream();
        test_level_held();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
